fb_write_arbiter: RTL and testbench

Sole owner of the frame buffer write port in the Tron display path. Shares the single `frameRAM` write port between the red bike trail writer, the blue bike trail writer and an internal clear/arena-draw sequencer. Converts pixel coordinates into packed two-pixel word writes (nibbles [3:0] and [11:8]) at the same address map the VGA read side uses: `x/2 + y*320`.

---
 rtl/fb_write_arbiter_if.sv | 42 ++++
 rtl/fb_write_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_fb_write_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_write_arbiter_if.sv
// Frame-buffer write arbiter bundle: clear control, the two trail request ports and the
// frame-buffer write/status side. The arbiter takes the slave view.
interface fb_write_arbiter_if;
  logic        clear_req;
  logic [3:0]  clear_color;
  logic [3:0]  border_color;

  logic        red_req;
  logic [9:0]  red_x;
  logic [9:0]  red_y;
  logic [3:0]  red_color;
  logic        red_ack;

  logic        blue_req;
  logic [9:0]  blue_x;
  logic [9:0]  blue_y;
  logic [3:0]  blue_color;
  logic        blue_ack;

  logic        fb_we;
  logic [18:0] fb_addr;
  logic [15:0] fb_data;
  logic        busy;
  logic        clear_done;
  logic        oob_err;

  modport master (
    output clear_req, clear_color, border_color,
    output red_req, red_x, red_y, red_color,
    output blue_req, blue_x, blue_y, blue_color,
    input  red_ack, blue_ack,
    input  fb_we, fb_addr, fb_data, busy, clear_done, oob_err
  );

  modport slave (
    input  clear_req, clear_color, border_color,
    input  red_req, red_x, red_y, red_color,
    input  blue_req, blue_x, blue_y, blue_color,
    output red_ack, blue_ack,
    output fb_we, fb_addr, fb_data, busy, clear_done, oob_err
  );
endinterface

// File: rtl/fb_write_arbiter.sv
// Owns the frame-buffer write port: round-robin red/blue trail writes plus a full-buffer clear.
// Optional FB_ARENA_BORDER_EN paints the outermost words with border_color during a clear.
module fb_write_arbiter #(
  parameter int unsigned H_WORDS = 320,
  parameter int unsigned V_LINES = 480
) (
  input logic            Clk,
  input logic            Reset,
  fb_write_arbiter_if.slave bus
);

  typedef enum logic {StIdle, StClear} state_e;

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;   // 0: red wins the next tie
  logic [8:0]  cx_q, cy_q;
  logic [18:0] clr_addr_q;
  logic [3:0]  clr_color_q;
  logic        we_q, we_d;
  logic [18:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        oob_q, oob_d;
  logic        last_wr_q, last_wr_d;
  logic        done_q;

  logic        grant_red, grant_blue;
  logic        red_oob, blue_oob;
  logic        clear_last, clear_step;
  logic [3:0]  fill_color;

  function automatic logic [18:0] pix_addr(input logic [9:0] x, input logic [9:0] y);
    return {10'd0, x[9:1]} + {1'b0, y, 8'd0} + {3'd0, y, 6'd0};
  endfunction

  function automatic logic [15:0] pack(input logic [3:0] c);
    return {4'h0, c, 4'h0, c};
  endfunction

  assign red_oob    = (bus.red_x >= 10'(2 * H_WORDS)) || (bus.red_y >= 10'(V_LINES));
  assign blue_oob   = (bus.blue_x >= 10'(2 * H_WORDS)) || (bus.blue_y >= 10'(V_LINES));
  assign clear_last = (cx_q == 9'(H_WORDS - 1)) && (cy_q == 9'(V_LINES - 1));
  assign clear_step = (state_q == StClear) && !bus.clear_req;

`ifdef FB_ARENA_BORDER_EN
  logic [3:0] brd_color_q;
  logic       on_border;

  assign on_border  = (cy_q == 9'd0) || (cy_q == 9'(V_LINES - 1)) ||
                      (cx_q == 9'd0) || (cx_q == 9'(H_WORDS - 1));
  assign fill_color = on_border ? brd_color_q : clr_color_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      brd_color_q <= 4'h0;
    end else if (bus.clear_req) begin
      brd_color_q <= bus.border_color;
    end
  end
`else
  logic unused_border;

  assign unused_border = ^bus.border_color;
  assign fill_color    = clr_color_q;
`endif

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a clear request always (re)starts the sweep
  always_comb begin
    state_d = state_q;
    if (bus.clear_req) begin
      state_d = StClear;
    end else if ((state_q == StClear) && clear_last) begin
      state_d = StIdle;
    end
  end

  // Output logic: grants, status
  always_comb begin
    grant_red  = 1'b0;
    grant_blue = 1'b0;
    if ((state_q == StIdle) && !bus.clear_req && Reset) begin
      if (bus.red_req && bus.blue_req) begin
        grant_red  = !last_grant_q;
        grant_blue = last_grant_q;
      end else begin
        grant_red  = bus.red_req;
        grant_blue = bus.blue_req;
      end
    end
  end

  assign bus.red_ack    = grant_red;
  assign bus.blue_ack   = grant_blue;
  assign bus.busy       = (state_q == StClear);
  assign bus.fb_we      = we_q;
  assign bus.fb_addr    = addr_q;
  assign bus.fb_data    = data_q;
  assign bus.clear_done = done_q;
  assign bus.oob_err    = oob_q;

  // Write-port datapath next state
  always_comb begin
    we_d         = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;
    last_grant_d = last_grant_q;
    oob_d        = oob_q | (grant_red & red_oob) | (grant_blue & blue_oob);
    last_wr_d    = clear_step && clear_last;
    if (bus.clear_req) begin
      oob_d = 1'b0;
    end
    if (grant_red && bus.blue_req) begin
      last_grant_d = 1'b1;
    end else if (grant_blue && bus.red_req) begin
      last_grant_d = 1'b0;
    end
    if (grant_red && !red_oob) begin
      we_d   = 1'b1;
      addr_d = pix_addr(bus.red_x, bus.red_y);
      data_d = pack(bus.red_color);
    end else if (grant_blue && !blue_oob) begin
      we_d   = 1'b1;
      addr_d = pix_addr(bus.blue_x, bus.blue_y);
      data_d = pack(bus.blue_color);
    end else if (clear_step) begin
      we_d   = 1'b1;
      addr_d = clr_addr_q;
      data_d = pack(fill_color);
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      we_q         <= 1'b0;
      addr_q       <= 19'd0;
      data_q       <= 16'd0;
      oob_q        <= 1'b0;
      last_grant_q <= 1'b0;
      last_wr_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      we_q         <= we_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      oob_q        <= oob_d;
      last_grant_q <= last_grant_d;
      last_wr_q    <= last_wr_d;
      done_q       <= last_wr_q;
    end
  end

  // Clear sweep counters; clr_addr_q tracks cx + cy * H_WORDS
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cx_q        <= 9'd0;
      cy_q        <= 9'd0;
      clr_addr_q  <= 19'd0;
      clr_color_q <= 4'h0;
    end else if (bus.clear_req) begin
      cx_q        <= 9'd0;
      cy_q        <= 9'd0;
      clr_addr_q  <= 19'd0;
      clr_color_q <= bus.clear_color;
    end else if (state_q == StClear) begin
      clr_addr_q <= clr_addr_q + 19'd1;
      if (cx_q == 9'(H_WORDS - 1)) begin
        cx_q <= 9'd0;
        cy_q <= cy_q + 9'd1;
      end else begin
        cx_q <= cx_q + 9'd1;
      end
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed self-checking bench for fb_write_arbiter; a reduced line count keeps clears short
// while the 320-word line pitch keeps the address map unchanged.
module tb_fb_write_arbiter;
  localparam int unsigned HW = 320;
  localparam int unsigned VL = 48;
  localparam int NW = HW * VL;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  fb_write_arbiter_if bus();

  fb_write_arbiter #(.H_WORDS(HW), .V_LINES(VL)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [15:0] pk(input logic [3:0] c);
    return {4'h0, c, 4'h0, c};
  endfunction

  function automatic logic [15:0] clr_word(input int a, input logic [3:0] c, input logic [3:0] b);
    logic on_b;
    on_b = 1'b0;
`ifdef FB_ARENA_BORDER_EN
    on_b = ((a / HW) == 0) || ((a / HW) == VL - 1) || ((a % HW) == 0) || ((a % HW) == HW - 1);
`endif
    return pk(on_b ? b : c);
  endfunction

  task automatic idle_inputs();
    bus.clear_req = 0; bus.clear_color = 0; bus.border_color = 0;
    bus.red_req = 0; bus.red_x = 0; bus.red_y = 0; bus.red_color = 0;
    bus.blue_req = 0; bus.blue_x = 0; bus.blue_y = 0; bus.blue_color = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.red_req = 1;
    #2;
    checks++; if (bus.fb_we !== 1'b0) begin failures++; $display("FAIL rst_fb_we got %b want 0", bus.fb_we); end
    checks++; if (bus.fb_addr !== 19'd0) begin failures++; $display("FAIL rst_fb_addr got %0d want 0", bus.fb_addr); end
    checks++; if (bus.fb_data !== 16'h0) begin failures++; $display("FAIL rst_fb_data got %h want 0", bus.fb_data); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got %b want 0", bus.busy); end
    checks++; if (bus.clear_done !== 1'b0) begin failures++; $display("FAIL rst_done got %b want 0", bus.clear_done); end
    checks++; if (bus.oob_err !== 1'b0) begin failures++; $display("FAIL rst_oob got %b want 0", bus.oob_err); end
    checks++; if (bus.red_ack !== 1'b0) begin failures++; $display("FAIL rst_red_ack got %b want 0", bus.red_ack); end
    bus.red_req = 0;
    @(negedge Clk) Reset = 1;
    step();
  endtask

  task automatic test_single_write();
    bus.red_req = 1; bus.red_x = 10'd100; bus.red_y = 10'd10; bus.red_color = 4'h5;
    #1;
    checks++; if (bus.red_ack !== 1'b1) begin failures++; $display("FAIL single_ack got %b want 1", bus.red_ack); end
    step();
    bus.red_req = 0;
    checks++; if (bus.fb_we !== 1'b1) begin failures++; $display("FAIL single_we got %b want 1", bus.fb_we); end
    checks++; if (bus.fb_addr !== 19'd3250) begin failures++; $display("FAIL single_addr got %0d want 3250", bus.fb_addr); end
    checks++; if (bus.fb_data !== 16'h0505) begin failures++; $display("FAIL single_data got %h want 0505", bus.fb_data); end
    step();
    checks++; if (bus.fb_we !== 1'b0) begin failures++; $display("FAIL single_we_drop got %b want 0", bus.fb_we); end
  endtask

  task automatic test_round_robin();
    logic exp_red;
    Reset = 0;
    #1;
    @(negedge Clk) Reset = 1;
    step();
    bus.red_req = 1; bus.red_x = 0; bus.red_y = 0; bus.red_color = 4'h1;
    bus.blue_req = 1; bus.blue_x = 2; bus.blue_y = 1; bus.blue_color = 4'h2;
    for (int i = 0; i < 6; i++) begin
      exp_red = (i % 2 == 0);
      #1;
      checks++;
      if (bus.red_ack !== exp_red || bus.blue_ack !== !exp_red) begin
        failures++; $display("FAIL rr_ack[%0d] got r=%b b=%b want r=%b", i, bus.red_ack, bus.blue_ack, exp_red);
      end
      step();
      checks++;
      if (bus.fb_we !== 1'b1 || bus.fb_addr !== (exp_red ? 19'd0 : 19'd321) ||
          bus.fb_data !== (exp_red ? 16'h0101 : 16'h0202)) begin
        failures++; $display("FAIL rr_write[%0d] got we=%b addr=%0d data=%h", i, bus.fb_we, bus.fb_addr, bus.fb_data);
      end
    end
    bus.red_req = 0; bus.blue_req = 0;
    step();
  endtask

  task automatic test_oob();
    bus.blue_req = 1; bus.blue_x = 10'd640; bus.blue_y = 0; bus.blue_color = 4'h3;
    #1;
    checks++; if (bus.blue_ack !== 1'b1) begin failures++; $display("FAIL oob_x_ack got %b want 1", bus.blue_ack); end
    step();
    bus.blue_req = 0;
    checks++; if (bus.fb_we !== 1'b0) begin failures++; $display("FAIL oob_x_we got %b want 0", bus.fb_we); end
    checks++; if (bus.oob_err !== 1'b1) begin failures++; $display("FAIL oob_flag got %b want 1", bus.oob_err); end
    bus.red_req = 1; bus.red_x = 0; bus.red_y = 10'(VL); bus.red_color = 4'h4;
    #1;
    checks++; if (bus.red_ack !== 1'b1) begin failures++; $display("FAIL oob_y_ack got %b want 1", bus.red_ack); end
    step();
    bus.red_req = 0;
    checks++; if (bus.fb_we !== 1'b0) begin failures++; $display("FAIL oob_y_we got %b want 0", bus.fb_we); end
    step(); step();
    checks++; if (bus.oob_err !== 1'b1) begin failures++; $display("FAIL oob_sticky got %b want 1", bus.oob_err); end
  endtask

  task automatic test_clear();
    int wr = 0, seq_err = 0, busy_err = 0, ack_busy = 0, done_cnt = 0;
    logic acked = 0;
    logic [15:0] d0 = 16'hxxxx, d321 = 16'hxxxx;
    bus.clear_req = 1; bus.clear_color = 4'h0; bus.border_color = 4'h8;
    bus.blue_req = 1; bus.blue_x = 4; bus.blue_y = 2; bus.blue_color = 4'h3;
    #1;
    checks++; if (bus.blue_ack !== 1'b0) begin failures++; $display("FAIL clr_prio_ack got %b want 0", bus.blue_ack); end
    step();
    bus.clear_req = 0; bus.clear_color = 4'hF; bus.border_color = 4'hF;
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL clr_busy_start got %b want 1", bus.busy); end
    checks++; if (bus.oob_err !== 1'b0) begin failures++; $display("FAIL clr_oob_cleared got %b want 0", bus.oob_err); end
    for (int i = 0; i < NW + 20 && !acked; i++) begin
      step();
      if (bus.clear_done === 1'b1) done_cnt++;
      if (bus.fb_we === 1'b1) begin
        if (bus.fb_addr !== 19'(wr) || bus.fb_data !== clr_word(wr, 4'h0, 4'h8)) seq_err++;
        if (wr == 0) d0 = bus.fb_data;
        if (wr == 321) d321 = bus.fb_data;
        wr++;
      end
      if (bus.blue_ack === 1'b1) begin
        acked = 1;
        if (bus.busy !== 1'b0) ack_busy++;
      end else if (bus.busy !== 1'b1) begin
        busy_err++;
      end
    end
    checks++; if (acked !== 1'b1) begin failures++; $display("FAIL clr_blue_ack got %b want 1", acked); end
    checks++; if (wr != NW) begin failures++; $display("FAIL clr_writes got %0d want %0d", wr, NW); end
    checks++; if (seq_err != 0) begin failures++; $display("FAIL clr_seq got %0d bad want 0", seq_err); end
    checks++; if (busy_err != 0) begin failures++; $display("FAIL clr_busy got %0d low want 0", busy_err); end
    checks++; if (ack_busy != 0) begin failures++; $display("FAIL clr_ack_busy got %0d want 0", ack_busy); end
`ifdef FB_ARENA_BORDER_EN
    checks++; if (d0 !== 16'h0808) begin failures++; $display("FAIL clr_addr0 got %h want 0808", d0); end
`else
    checks++; if (d0 !== 16'h0000) begin failures++; $display("FAIL clr_addr0 got %h want 0000", d0); end
`endif
    checks++; if (d321 !== 16'h0000) begin failures++; $display("FAIL clr_addr321 got %h want 0000", d321); end
    step();
    bus.blue_req = 0;
    if (bus.clear_done === 1'b1) done_cnt++;
    checks++;
    if (bus.fb_we !== 1'b1 || bus.fb_addr !== 19'd642 || bus.fb_data !== 16'h0303) begin
      failures++; $display("FAIL clr_blue_write got we=%b addr=%0d data=%h want 1/642/0303", bus.fb_we, bus.fb_addr, bus.fb_data);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.clear_done === 1'b1) done_cnt++;
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL clr_done_pulses got %0d want 1", done_cnt); end
  endtask

  task automatic test_restart();
    int wr = 0, wr2 = 0, err = 0, done_cnt = 0;
    bus.clear_req = 1; bus.clear_color = 4'h1; bus.border_color = 4'h1;
    step();
    bus.clear_req = 0;
    for (int i = 0; i < NW && wr < 1000; i++) begin
      step();
      if (bus.clear_done === 1'b1) done_cnt++;
      if (bus.fb_we === 1'b1) begin
        if (bus.fb_data !== 16'h0101) err++;
        wr++;
      end
    end
    bus.clear_req = 1; bus.clear_color = 4'h6; bus.border_color = 4'h6;
    step();
    bus.clear_req = 0; bus.clear_color = 4'h0; bus.border_color = 4'h0;
    checks++; if (bus.fb_we !== 1'b0) begin failures++; $display("FAIL rs_restart_we got %b want 0", bus.fb_we); end
    for (int i = 0; i < NW + 20 && done_cnt == 0; i++) begin
      step();
      if (bus.clear_done === 1'b1) done_cnt++;
      if (bus.fb_we === 1'b1) begin
        if (bus.fb_addr !== 19'(wr2) || bus.fb_data !== 16'h0606) err++;
        wr2++;
      end
    end
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.clear_done === 1'b1) done_cnt++;
    end
    checks++; if (wr + wr2 != 1000 + NW) begin failures++; $display("FAIL rs_total got %0d want %0d", wr + wr2, 1000 + NW); end
    checks++; if (err != 0) begin failures++; $display("FAIL rs_data got %0d bad want 0", err); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL rs_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_mid_clear();
    int wr = 0;
    bus.clear_req = 1; bus.clear_color = 4'h2;
    step();
    bus.clear_req = 0;
    for (int i = 0; i < NW && wr < 500; i++) begin
      step();
      if (bus.fb_we === 1'b1) wr++;
    end
    #2 Reset = 0;
    #1;
    checks++; if (bus.fb_we !== 1'b0) begin failures++; $display("FAIL mid_rst_we got %b want 0", bus.fb_we); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got %b want 0", bus.busy); end
    bus.red_req = 1; bus.red_x = 6; bus.red_y = 1; bus.red_color = 4'h7;
    #1;
    checks++; if (bus.red_ack !== 1'b0) begin failures++; $display("FAIL mid_rst_ack got %b want 0", bus.red_ack); end
    @(negedge Clk) Reset = 1;
    #1;
    checks++; if (bus.red_ack !== 1'b1) begin failures++; $display("FAIL post_rst_ack got %b want 1", bus.red_ack); end
    step();
    bus.red_req = 0;
    checks++;
    if (bus.fb_we !== 1'b1 || bus.fb_addr !== 19'd323 || bus.fb_data !== 16'h0707) begin
      failures++; $display("FAIL post_rst_write got we=%b addr=%0d data=%h want 1/323/0707", bus.fb_we, bus.fb_addr, bus.fb_data);
    end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL post_rst_busy got %b want 0", bus.busy); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_oob();
    test_clear();
    test_restart();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
